// File: rtl/scan_tick_gen.sv
// Scan timebase for LED-matrix drivers: 1-cycle tick every PERIOD+1 clocks,
// toggling clk_out, wrapping row-phase counter, periodic or one-shot operation.
module scan_tick_gen #(
    parameter int CNT_W          = 16,
    parameter int DEFAULT_PERIOD = 6250,
    parameter int NUM_PHASE      = 8,
    localparam int PH_W          = $clog2(NUM_PHASE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             start,
    input  logic             period_load,
    input  logic [CNT_W-1:0] period_in,
    output logic             tick,
    output logic             clk_out,
    output logic [PH_W-1:0]  phase,
    output logic             phase_wrap,
    output logic             busy
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] DEF_P   = CNT_W'(DEFAULT_PERIOD);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(NUM_PHASE - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              tick_q, tick_d;
    logic              clk_out_q, clk_out_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              phase_wrap_q, phase_wrap_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        clk_out_d    = clk_out_q;
        phase_d      = phase_q;
        tick_d       = 1'b0;
        phase_wrap_d = 1'b0;

        if (en) begin
            // A period load restarts the count and pre-empts any terminal event.
            if (period_load) begin
                period_d = period_in;
                cnt_d    = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_d = '0;
                        if (!mode || start) state_d = RUN;
                    end
                    RUN: begin
                        if (cnt_q == period_q) begin
                            cnt_d     = '0;
                            tick_d    = 1'b1;
                            clk_out_d = ~clk_out_q;
                            if (phase_q == PH_LAST) begin
                                phase_d      = '0;
                                phase_wrap_d = 1'b1;
                            end else begin
                                phase_d = phase_q + 1'b1;
                            end
                            if (mode) state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            period_q     <= DEF_P;
            tick_q       <= 1'b0;
            clk_out_q    <= 1'b0;
            phase_q      <= '0;
            phase_wrap_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            tick_q       <= tick_d;
            clk_out_q    <= clk_out_d;
            phase_q      <= phase_d;
            phase_wrap_q <= phase_wrap_d;
            busy_q       <= busy_d;
        end
    end

    assign tick       = tick_q;
    assign clk_out    = clk_out_q;
    assign phase      = phase_q;
    assign phase_wrap = phase_wrap_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_scan_tick_gen.sv
// Directed bench for scan_tick_gen: one task per scenario, inline checks.
module tb_scan_tick_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic        mode;
    logic        start;
    logic        period_load;
    logic [15:0] period_in;
    logic        tick;
    logic        clk_out;
    logic [2:0]  phase;
    logic        phase_wrap;
    logic        busy;

    int tests_run = 0;
    int fails     = 0;

    scan_tick_gen #(.CNT_W(16), .DEFAULT_PERIOD(6250), .NUM_PHASE(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start),
        .period_load(period_load), .period_in(period_in),
        .tick(tick), .clk_out(clk_out), .phase(phase),
        .phase_wrap(phase_wrap), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until tick is seen; n = steps taken, or -1 if the bound expires.
    task automatic wait_tick(input int max_cyc, output int n);
        int i;
        n = -1;
        i = 0;
        while (n < 0 && i < max_cyc) begin
            step();
            i++;
            if (tick === 1'b1) n = i;
        end
    endtask

    // Reset, then load period p (state stays IDLE), then one edge to enter RUN.
    task automatic restart_periodic(input logic [15:0] p);
        rst = 1'b1; en = 1'b0; mode = 1'b0; start = 1'b0; period_load = 1'b0;
        step();
        rst = 1'b0; en = 1'b1; period_load = 1'b1; period_in = p;
        step();
        period_load = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 1'b0; start = 1'b1; period_load = 1'b1; period_in = 16'd3;
        step();
        step();
        tests_run++;
        if ({tick, clk_out, phase, phase_wrap, busy} !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 0000000", {tick, clk_out, phase, phase_wrap, busy});
        end
        rst = 1'b0; en = 1'b0; start = 1'b0; period_load = 1'b0;
        step();
    endtask

    task automatic test_default_period();
        int n;
        en = 1'b1; mode = 1'b0;
        step();
        tests_run++;
        if (busy !== 1'b1) begin fails++; $display("FAIL default_busy: got %b expected 1", busy); end
        wait_tick(7000, n);
        tests_run++;
        if (n !== 6251) begin fails++; $display("FAIL default_first_tick: got %0d expected 6251", n); end
        tests_run++;
        if (clk_out !== 1'b1) begin fails++; $display("FAIL default_clk_out_1: got %b expected 1", clk_out); end
        step();
        tests_run++;
        if (tick !== 1'b0) begin fails++; $display("FAIL default_tick_width: got %b expected 0", tick); end
        wait_tick(7000, n);
        tests_run++;
        if (n !== 6250) begin fails++; $display("FAIL default_second_tick: got %0d expected 6250", n); end
        tests_run++;
        if (clk_out !== 1'b0 || phase !== 3'd2) begin
            fails++;
            $display("FAIL default_after_two: clk_out=%b phase=%0d expected clk_out=0 phase=2", clk_out, phase);
        end
    endtask

    task automatic test_phase_wrap();
        int n;
        restart_periodic(16'd3);
        for (int k = 1; k <= 8; k++) begin
            wait_tick(10, n);
            tests_run++;
            if (n !== 4 || phase !== 3'(k % 8) || phase_wrap !== (k == 8)) begin
                fails++;
                $display("FAIL phase_tick%0d: spacing=%0d phase=%0d wrap=%b expected 4 %0d %b",
                         k, n, phase, phase_wrap, k % 8, (k == 8));
            end
        end
        step();
        tests_run++;
        if (phase_wrap !== 1'b0) begin fails++; $display("FAIL phase_wrap_width: got %b expected 0", phase_wrap); end
    endtask

    task automatic test_one_shot();
        int n;
        int extra;
        rst = 1'b1; step();
        rst = 1'b0; en = 1'b1; mode = 1'b1; period_load = 1'b1; period_in = 16'd5;
        step();
        period_load = 1'b0;
        step(); step();
        tests_run++;
        if (busy !== 1'b0) begin fails++; $display("FAIL oneshot_idle_wait: got busy=%b expected 0", busy); end
        start = 1'b1;
        step();
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin fails++; $display("FAIL oneshot_busy_start: got %b expected 1", busy); end
        n = 0;
        while (busy === 1'b1 && n < 20) begin step(); n++; end
        tests_run++;
        if (n !== 6 || tick !== 1'b1 || clk_out !== 1'b1) begin
            fails++;
            $display("FAIL oneshot_end: busy_cycles=%0d tick=%b clk_out=%b expected 6 1 1", n, tick, clk_out);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (tick === 1'b1 || busy === 1'b1) extra++;
        end
        tests_run++;
        if (extra !== 0 || clk_out !== 1'b1) begin
            fails++;
            $display("FAIL oneshot_single: extra_active=%0d clk_out=%b expected 0 1", extra, clk_out);
        end
        mode = 1'b0;
    endtask

    task automatic test_enable_pause();
        int n;
        int bad;
        logic       co;
        logic [2:0] ph;
        restart_periodic(16'd3);
        wait_tick(10, n);
        step(); step();
        en = 1'b0; co = clk_out; ph = phase; bad = 0;
        for (int i = 0; i < 10; i++) begin
            period_load = (i == 4); period_in = 16'd9;
            step();
            if (tick !== 1'b0 || clk_out !== co || phase !== ph || busy !== 1'b1) bad++;
        end
        period_load = 1'b0;
        tests_run++;
        if (bad !== 0) begin fails++; $display("FAIL pause_frozen: got %0d bad cycles expected 0", bad); end
        en = 1'b1;
        wait_tick(20, n);
        tests_run++;
        if (n !== 2 || phase !== 3'd2) begin
            fails++;
            $display("FAIL pause_resume: steps=%0d phase=%0d expected 2 2", n, phase);
        end
        wait_tick(20, n);
        tests_run++;
        if (n !== 4) begin fails++; $display("FAIL pause_load_ignored: got %0d expected 4", n); end
    endtask

    task automatic test_load_on_terminal();
        int n;
        logic       co;
        logic [2:0] ph;
        co = clk_out; ph = phase;
        step(); step(); step();
        period_load = 1'b1; period_in = 16'd2;
        step();
        period_load = 1'b0;
        tests_run++;
        if (tick !== 1'b0 || clk_out !== co || phase !== ph) begin
            fails++;
            $display("FAIL load_terminal: tick=%b clk_out=%b phase=%0d expected 0 %b %0d", tick, clk_out, phase, co, ph);
        end
        wait_tick(10, n);
        tests_run++;
        if (n !== 3) begin fails++; $display("FAIL load_terminal_next: got %0d expected 3", n); end
        wait_tick(10, n);
        tests_run++;
        if (n !== 3) begin fails++; $display("FAIL load_terminal_period: got %0d expected 3", n); end
    endtask

    task automatic test_period_zero();
        int n;
        int bad;
        logic co;
        restart_periodic(16'd0);
        wait_tick(5, n);
        tests_run++;
        if (n !== 1) begin fails++; $display("FAIL zero_first: got %0d expected 1", n); end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            co = clk_out;
            step();
            if (tick !== 1'b1 || clk_out !== ~co) bad++;
        end
        tests_run++;
        if (bad !== 0) begin fails++; $display("FAIL zero_every_cycle: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_reset_midrun();
        int n;
        restart_periodic(16'd3);
        for (int k = 0; k < 5; k++) wait_tick(10, n);
        step(); step();
        tests_run++;
        if (phase !== 3'd5) begin fails++; $display("FAIL midrun_setup_phase: got %0d expected 5", phase); end
        rst = 1'b1;
        step();
        tests_run++;
        if ({tick, clk_out, phase, phase_wrap, busy} !== 7'b0) begin
            fails++;
            $display("FAIL midrun_reset: got %b expected 0000000", {tick, clk_out, phase, phase_wrap, busy});
        end
        rst = 1'b0;
        step();
        tests_run++;
        if (busy !== 1'b1) begin fails++; $display("FAIL midrun_restart_busy: got %b expected 1", busy); end
        wait_tick(20, n);
        tests_run++;
        if (n !== -1) begin fails++; $display("FAIL midrun_default_period: tick after %0d expected none within 20", n); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; start = 1'b0; period_load = 1'b0; period_in = '0;
        test_reset();
        test_default_period();
        test_phase_wrap();
        test_one_shot();
        test_enable_pause();
        test_load_on_terminal();
        test_period_zero();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
